// File: rtl/sim_ctrl_pkg.sv
// sim_ctrl_pkg: shared constants for the simulation-control OCP slave.
//   - OCP command and response encodings
//   - default bus widths
//   - register word indices (address bits [11:2])
package sim_ctrl_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int BEN_WIDTH  = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    OCP_CMD_IDLE  = 3'd0,
    OCP_CMD_WRITE = 3'd1,
    OCP_CMD_READ  = 3'd2
  } ocp_cmd_e;

  typedef enum logic [1:0] {
    OCP_RESP_NULL = 2'd0,
    OCP_RESP_DVA  = 2'd1,
    OCP_RESP_FAIL = 2'd2,
    OCP_RESP_ERR  = 2'd3
  } ocp_resp_e;

  localparam logic [9:0] CTRL_WORD  = 10'd0;
  localparam logic [9:0] DELAY_WORD = 10'd1;

endpackage

// File: rtl/sim_ctrl_if.sv
// sim_ctrl_if: OCP request/response bundle between an interconnect master
// and the sim_ctrl slave.
//   MAddr      byte address            (master -> slave)
//   MCmd       command IDLE/WRITE/READ (master -> slave)
//   MData      write data              (master -> slave)
//   MByteEn    per-byte write enables  (master -> slave)
//   SCmdAccept command accept          (slave -> master)
//   SData      read data               (slave -> master)
//   SResp      response NULL/DVA/ERR   (slave -> master)
interface sim_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BEN_WIDTH  = DATA_WIDTH / 8
) ();

  logic [ADDR_WIDTH-1:0] MAddr;
  logic [2:0]            MCmd;
  logic [DATA_WIDTH-1:0] MData;
  logic [BEN_WIDTH-1:0]  MByteEn;
  logic                  SCmdAccept;
  logic [DATA_WIDTH-1:0] SData;
  logic [1:0]            SResp;

  modport master (
    output MAddr, MCmd, MData, MByteEn,
    input  SCmdAccept, SData, SResp
  );

  modport slave (
    input  MAddr, MCmd, MData, MByteEn,
    output SCmdAccept, SData, SResp
  );

endinterface

// File: rtl/sim_ctrl_terminator.sv
// sim_ctrl_terminator: countdown that ends the simulation.
//   clk, rst     clock, asynchronous active-high reset
//   trigger_i    start request; ignored while a countdown is running
//   delay_i      cycles to count down from
//   err_i        termination status captured with the trigger
//   active_o     countdown running
//   done_o       counter has reached zero; the next rising edge ends the run
//   err_o        latched termination status
// With FINISH_EN set, the edge that consumes done_o prints the pass/fail
// message and calls $finish. That edge is delay_i+1 edges after the trigger.
module sim_ctrl_terminator #(
  parameter int CNT_WIDTH = 32,
  parameter bit FINISH_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trigger_i,
  input  logic [CNT_WIDTH-1:0] delay_i,
  input  logic                 err_i,
  output logic                 active_o,
  output logic                 done_o,
  output logic                 err_o
);

  logic                 active_q, active_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 err_q, err_d;

  assign done_o   = active_q && (count_q == '0);
  assign active_o = active_q;
  assign err_o    = err_q;

  always_comb begin
    // NOTE: every next-state signal gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    active_d = active_q;
    count_d  = count_q;
    err_d    = err_q;
    if (active_q) begin
      // A running countdown cannot be restarted or altered by new triggers.
      if (count_q == '0) active_d = 1'b0;
      else               count_d  = count_q - 1'b1;
    end else if (trigger_i) begin
      active_d = 1'b1;
      count_d  = delay_i;
      err_d    = err_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  if (FINISH_EN) begin : g_finish
`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
      if (!rst && done_o) begin
        if (err_q) $display("%0t SIMULATION FINISHED: FAIL", $time);
        else       $display("%0t SIMULATION FINISHED: PASS", $time);
        $finish;
      end
    end
`endif
  end

endmodule

// File: rtl/sim_ctrl.sv
// sim_ctrl: simulation-only OCP slave that lets target software end the run.
//   clk, rst  clock, asynchronous active-high reset
//   ocp       OCP slave port (sim_ctrl_if.slave)
// Registers (word index = MAddr[11:2]):
//   0 CTRL  : bit0 TERMINATE, bit31 ERROR status, other bits plain storage
//   1 DELAY : countdown length in clock cycles
// Commands are accepted in the same cycle; the response (DVA for mapped
// READ/WRITE, ERR otherwise) is registered one cycle after the command.
module sim_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = sim_ctrl_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = sim_ctrl_pkg::DATA_WIDTH,
  parameter int BEN_WIDTH  = DATA_WIDTH / 8,
  parameter bit FINISH_EN  = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  sim_ctrl_if.slave ocp
);

  logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] delay_q, delay_d;
  logic [DATA_WIDTH-1:0] sdata_q, sdata_d;
  ocp_resp_e             sresp_q, sresp_d;
  logic [DATA_WIDTH-1:0] wr_val;
  logic [9:0]            word;
  logic                  is_wr, is_rd, is_ctrl, is_delay;
  logic                  trigger;
  logic                  term_active, term_fire, term_err;

  // Only bits [11:2] select a register; the rest of the address is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ocp.MAddr[ADDR_WIDTH-1:12], ocp.MAddr[1:0], term_active};

  assign word     = ocp.MAddr[11:2];
  assign is_wr    = (ocp.MCmd == OCP_CMD_WRITE);
  assign is_rd    = (ocp.MCmd == OCP_CMD_READ);
  assign is_ctrl  = (word == CTRL_WORD);
  assign is_delay = (word == DELAY_WORD);

  assign ocp.SCmdAccept = is_wr || is_rd;
  assign ocp.SData      = sdata_q;
  assign ocp.SResp      = sresp_q;

  always_comb begin
    ctrl_d  = ctrl_q;
    delay_d = delay_q;
    sdata_d = sdata_q;
    sresp_d = OCP_RESP_NULL;

    // Byte-lane merge of write data over the addressed register.
    wr_val = is_ctrl ? ctrl_q : delay_q;
    for (int b = 0; b < BEN_WIDTH; b++) begin
      if (ocp.MByteEn[b]) wr_val[b*8 +: 8] = ocp.MData[b*8 +: 8];
    end

    if (ocp.MCmd != OCP_CMD_IDLE) begin
      if ((is_wr || is_rd) && (is_ctrl || is_delay)) begin
        sresp_d = OCP_RESP_DVA;
        if (is_rd) begin
          sdata_d = is_ctrl ? ctrl_q : delay_q;
        end else if (is_ctrl) begin
          ctrl_d = wr_val;
        end else begin
          delay_d = wr_val;
        end
      end else begin
        // Unmapped word or unsupported command code.
        sresp_d = OCP_RESP_ERR;
        sdata_d = '0;
      end
    end
  end

  // Trigger on the value CTRL will hold after this write, not the old one.
  assign trigger = is_wr && is_ctrl && ctrl_d[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= '0;
      delay_q <= '0;
      sdata_q <= '0;
      sresp_q <= OCP_RESP_NULL;
    end else begin
      ctrl_q  <= ctrl_d;
      delay_q <= delay_d;
      sdata_q <= sdata_d;
      sresp_q <= sresp_d;
    end
  end

  sim_ctrl_terminator #(
    .CNT_WIDTH (DATA_WIDTH),
    .FINISH_EN (FINISH_EN)
  ) u_term (
    .clk       (clk),
    .rst       (rst),
    .trigger_i (trigger),
    .delay_i   (delay_q),
    .err_i     (ctrl_d[DATA_WIDTH-1]),
    .active_o  (term_active),
    .done_o    (term_fire),
    .err_o     (term_err)
  );

endmodule

// File: tb/tb_sim_ctrl.sv
// tb_sim_ctrl: directed bench for sim_ctrl. The DUT is built with its
// $finish disabled; termination is observed on the internal done/err
// signals, which go high in the cycle before the edge that would end the run.
module tb_sim_ctrl;
  import sim_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  sim_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ocp ();

  sim_ctrl #(.FINISH_EN(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .ocp (ocp.slave)
  );

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  ben;
    logic        exp_acc;
    logic [1:0]  exp_resp;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [2:0] cmd, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] ben,
                               input logic acc, input logic [1:0] resp,
                               input logic chk, input logic [31:0] exp_data);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.data = data; v.ben = ben;
    v.exp_acc = acc; v.exp_resp = resp; v.chk_data = chk; v.exp_data = exp_data;
    return v;
  endfunction

  task automatic drive_idle();
    ocp.MCmd    = OCP_CMD_IDLE;
    ocp.MAddr   = '0;
    ocp.MData   = '0;
    ocp.MByteEn = '0;
  endtask

  // Issue one command starting at a negedge; returns at the next negedge.
  task automatic bus_cmd(input logic [2:0] cmd, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] ben);
    ocp.MCmd = cmd; ocp.MAddr = addr; ocp.MData = data; ocp.MByteEn = ben;
    @(posedge clk);
    #1 drive_idle();
    @(negedge clk);
  endtask

  task automatic bus_write(input string name, input logic [31:0] addr, input logic [31:0] data);
    bus_cmd(OCP_CMD_WRITE, addr, data, 4'hF);
    check({name, " resp"}, {30'b0, ocp.SResp}, {30'b0, OCP_RESP_DVA});
  endtask

  task automatic bus_read(input string name, input logic [31:0] addr, input logic [31:0] exp);
    bus_cmd(OCP_CMD_READ, addr, 32'h0, 4'h0);
    check({name, " resp"}, {30'b0, ocp.SResp}, {30'b0, OCP_RESP_DVA});
    check({name, " data"}, ocp.SData, exp);
  endtask

  // Sample done at negedges k_start..k_end after the trigger edge (k_start's
  // negedge is the current time). done must be high only at k == exp_k.
  task automatic watch(input string name, input int k_start, input int k_end,
                       input int exp_k, input logic exp_err);
    for (int k = k_start; k <= k_end; k++) begin
      if (k != k_start) @(negedge clk);
      check($sformatf("%s done k=%0d", name, k), {31'b0, dut.term_fire}, {31'b0, k == exp_k});
      if (k == exp_k)
        check($sformatf("%s err k=%0d", name, k), {31'b0, dut.term_err}, {31'b0, exp_err});
    end
  endtask

  initial begin
    vecs[0]  = mkv(3'd1, 32'h0000_0000, 32'h000F_FFF0, 4'hF, 1'b1, 2'd1, 1'b1, 32'h0000_0000);
    vecs[1]  = mkv(3'd2, 32'h0000_0000, 32'h0,         4'h0, 1'b1, 2'd1, 1'b1, 32'h000F_FFF0);
    vecs[2]  = mkv(3'd1, 32'h0000_0004, 32'h1122_3344, 4'hF, 1'b1, 2'd1, 1'b1, 32'h000F_FFF0);
    vecs[3]  = mkv(3'd1, 32'h0000_0004, 32'hAABB_CCDD, 4'h1, 1'b1, 2'd1, 1'b1, 32'h000F_FFF0);
    vecs[4]  = mkv(3'd2, 32'h0000_1007, 32'h0,         4'h0, 1'b1, 2'd1, 1'b1, 32'h1122_33DD);
    vecs[5]  = mkv(3'd2, 32'h0000_0008, 32'h0,         4'hF, 1'b1, 2'd3, 1'b1, 32'h0000_0000);
    vecs[6]  = mkv(3'd2, 32'h0000_0000, 32'h0,         4'h0, 1'b1, 2'd1, 1'b1, 32'h000F_FFF0);
    vecs[7]  = mkv(3'd0, 32'h0000_0004, 32'h0,         4'hF, 1'b0, 2'd0, 1'b1, 32'h000F_FFF0);
    vecs[8]  = mkv(3'd3, 32'h0000_0000, 32'h0,         4'hF, 1'b0, 2'd3, 1'b1, 32'h0000_0000);
    vecs[9]  = mkv(3'd1, 32'h0000_0008, 32'h1234_5678, 4'hF, 1'b1, 2'd3, 1'b1, 32'h0000_0000);
    vecs[10] = mkv(3'd1, 32'h0000_0000, 32'hFF00_0000, 4'h8, 1'b1, 2'd1, 1'b1, 32'h0000_0000);
    vecs[11] = mkv(3'd2, 32'h0000_0000, 32'h0,         4'h0, 1'b1, 2'd1, 1'b1, 32'hFF0F_FFF0);
    vecs[12] = mkv(3'd1, 32'h0000_0000, 32'h0000_0000, 4'hF, 1'b1, 2'd1, 1'b1, 32'hFF0F_FFF0);
    vecs[13] = mkv(3'd2, 32'h0000_0003, 32'h0,         4'h0, 1'b1, 2'd1, 1'b1, 32'h0000_0000);
    vecs[14] = mkv(3'd2, 32'hFFFF_F004, 32'h0,         4'h0, 1'b1, 2'd1, 1'b1, 32'h1122_33DD);

    // Reset state.
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    check("reset resp", {30'b0, ocp.SResp}, {30'b0, OCP_RESP_NULL});
    check("reset data", ocp.SData, 32'h0);
    check("reset accept", {31'b0, ocp.SCmdAccept}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back table: command i is driven while response i-1 is checked.
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) begin
        ocp.MCmd = vecs[i].cmd; ocp.MAddr = vecs[i].addr;
        ocp.MData = vecs[i].data; ocp.MByteEn = vecs[i].ben;
      end else begin
        drive_idle();
      end
      #1;
      if (i < NV)
        check($sformatf("vec%0d accept", i), {31'b0, ocp.SCmdAccept}, {31'b0, vecs[i].exp_acc});
      if (i > 0) begin
        check($sformatf("vec%0d resp", i-1), {30'b0, ocp.SResp}, {30'b0, vecs[i-1].exp_resp});
        if (vecs[i-1].chk_data)
          check($sformatf("vec%0d data", i-1), ocp.SData, vecs[i-1].exp_data);
      end
      check($sformatf("vec%0d no done", i), {31'b0, dut.term_fire}, 32'h0);
      @(posedge clk);
      @(negedge clk);
    end

    // PASS countdown, DELAY=8: done at k=8, so $finish would fall on edge 9.
    bus_write("A delay wr", 32'h4, 32'h0000_0008);
    bus_read("A delay rd", 32'h4, 32'h0000_0008);
    bus_write("A ctrl wr", 32'h0, 32'h0000_0001);
    watch("A", 0, 12, 8, 1'b0);

    // FAIL status, with CTRL/DELAY writes mid-countdown that must not restart it.
    bus_write("B ctrl wr", 32'h0, 32'h8000_0001);
    watch("B", 0, 2, 8, 1'b1);
    bus_write("B ctrl mid", 32'h0, 32'h0000_0001);
    bus_write("B delay mid", 32'h4, 32'h0000_0002);
    watch("B", 4, 12, 8, 1'b1);
    bus_read("B ctrl rd", 32'h0, 32'h0000_0001);
    bus_read("B delay rd", 32'h4, 32'h0000_0002);

    // DELAY=0: done immediately after the trigger edge.
    bus_write("C delay wr", 32'h4, 32'h0);
    bus_write("C ctrl wr", 32'h0, 32'h0000_0001);
    watch("C", 0, 3, 0, 1'b0);

    // Reset during a DELAY=20 countdown cancels it.
    bus_write("D delay wr", 32'h4, 32'd20);
    bus_read("D delay rd", 32'h4, 32'd20);
    bus_write("D ctrl wr", 32'h0, 32'h0000_0001);
    watch("D pre", 0, 4, -1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("D rst resp", {30'b0, ocp.SResp}, {30'b0, OCP_RESP_NULL});
    check("D rst data", ocp.SData, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    watch("D post", 0, 30, -1, 1'b0);
    bus_read("D ctrl rd", 32'h0, 32'h0);
    bus_read("D delay rd", 32'h4, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
